instr_fetch_buffer: RTL and testbench

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/instr_fetch_buffer_if.sv | 47 ++++
 rtl/instr_fetch_buffer_fetch_fifo.sv | 91 +++++++++
 rtl/instr_fetch_buffer.sv | 120 ++++++++++++
 tb/tb_instr_fetch_buffer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// Package    : riscv_pkg
// Description: XLEN-independent RISC-V constants and the fetch-queue entry type.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int          ILEN             = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]     pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Drops the low two bits so the address lands on a 32-bit instruction boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_buffer_if.sv
// ============================================================================
// Interface  : instr_fetch_buffer_if
// Description: Instruction-memory, redirect and decoder handshake bundle.
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_buffer_if;
    import riscv_pkg::*;

    logic            imem_req;
    logic [31:0]     imem_addr;
    logic [ILEN-1:0] imem_rdata;
    logic            redirect_en;
    logic [31:0]     redirect_addr;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr;
    logic [31:0]     instr_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  redirect_en,
        input  redirect_addr,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output redirect_en,
        output redirect_addr,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_buffer_fetch_fifo.sv
// ============================================================================
// Module     : fetch_fifo
// Description: Circular-buffer queue of {pc,instr} entries with flush.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   flush,
    input  wire logic                   push,
    input  wire fetch_entry_t           push_data,
    input  wire logic                   pop,
    output fetch_entry_t                head,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    // A push into a full queue is legal only when the head leaves the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_buffer.sv
// ============================================================================
// Module     : instr_fetch_buffer
// Description: Sequential instruction prefetcher feeding a decoder queue.
//              FETCH_MISALIGN_CHECK_EN adds a sticky misalign_err output.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_buffer
    import riscv_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    instr_fetch_buffer_if.master   bus
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                   misalign_err
`endif
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;

    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  fifo_push_data;
    logic          fifo_push;
    logic          fifo_pop;
    logic [CW-1:0] occupancy;
    logic          fetch_req;
    logic [31:0]   redirect_target;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_err_q, misalign_err_d;

    assign redirect_target = word_align(bus.redirect_addr);

    always_comb begin
        misalign_err_d = misalign_err_q;
        if (bus.redirect_en && (bus.redirect_addr[1:0] != 2'b00)) begin
            misalign_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err_q <= 1'b0;
        end else begin
            misalign_err_q <= misalign_err_d;
        end
    end

    assign misalign_err = misalign_err_q;
`else
    assign redirect_target = bus.redirect_addr;
`endif

    // Counting the in-flight slot guarantees every returning word has a home.
    assign occupancy = fifo_count + {{(CW-1){1'b0}}, inflight_q};
    assign fetch_req = rst_n && !bus.redirect_en && (occupancy < DEPTH_C);

    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = fetch_req;
        if (bus.redirect_en) begin
            pc_d = redirect_target;
        end else if (fetch_req) begin
            pc_d          = pc_q + PC_STEP;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // A response landing in a redirect cycle belongs to the abandoned path.
    assign fifo_push          = inflight_q && !bus.redirect_en;
    assign fifo_pop           = bus.instr_valid && bus.instr_ready;
    assign fifo_push_data.pc    = inflight_pc_q;
    assign fifo_push_data.instr = bus.imem_rdata;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.redirect_en),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign bus.imem_req    = fetch_req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (fifo_count != '0);
    assign bus.instr       = bus.instr_valid ? fifo_head.instr : '0;
    assign bus.instr_pc    = bus.instr_valid ? fifo_head.pc    : '0;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_buffer.sv
// ============================================================================
// Module     : tb_instr_fetch_buffer
// Description: Directed self-checking bench for instr_fetch_buffer (DEPTH=4).
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_buffer;
    import riscv_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_buffer_if bus ();

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_err;
`endif

    instr_fetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    // Memory answers exactly one cycle after the address is presented.
    always @(posedge clk) bus.imem_rdata <= memf(bus.imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int          nreq;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;

        bus.redirect_en   = 1'b0;
        bus.redirect_addr = '0;
        bus.instr_ready   = 1'b0;
        rst_n             = 1'b0;
        repeat (3) tick();
        check("rst_req",   bus.imem_req,    0);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_instr", bus.instr,       0);
        check("rst_pc",    bus.instr_pc,    0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("rst_misalign", misalign_err, 0);
`endif

        // Cycle 0 after release: first request at RESET_PC.
        rst_n = 1'b1;
        #1;
        check("c0_req",  bus.imem_req,  1);
        check("c0_addr", bus.imem_addr, 32'h0);
        tick();
        check("c1_valid", bus.instr_valid, 0);
        check("c1_addr",  bus.imem_addr,   32'h4);
        tick();
        check("c2_valid", bus.instr_valid, 1);
        check("c2_pc",    bus.instr_pc,    32'h0);
        check("c2_instr", bus.instr,       memf(32'h0));

        // Backpressure: cycles 2..9 with instr_ready=0, two requests already seen.
        nreq     = 2;
        exp_addr = 32'h8;
        for (int i = 2; i < 10; i++) begin
            if (bus.imem_req) begin
                check("bp_addr", bus.imem_addr, exp_addr);
                exp_addr = exp_addr + 4;
                nreq++;
            end
            tick();
        end
        check("bp_nreq",   nreq,          4);
        check("bp_noreq",  bus.imem_req,  0);
        check("bp_headpc", bus.instr_pc,  32'h0);

        // Release backpressure and stream: no lost words, one per cycle.
        bus.instr_ready = 1'b1;
        #1;
        exp_pc = 32'h0;
        for (int i = 0; i < 12; i++) begin
            check("st_valid", bus.instr_valid, 1);
            check("st_pc",    bus.instr_pc,    exp_pc);
            check("st_instr", bus.instr,       memf(exp_pc));
            exp_pc = exp_pc + 4;
            tick();
        end

        // Stall one cycle so three entries are queued, then redirect to 0x40.
        bus.instr_ready = 1'b0;
        tick();
        check("pre_rd_valid", bus.instr_valid, 1);
        check("pre_rd_pc",    bus.instr_pc,    exp_pc);
        bus.redirect_en   = 1'b1;
        bus.redirect_addr = 32'h40;
        #1;
        check("rd_req", bus.imem_req, 0);
        tick();
        bus.redirect_en = 1'b0;
        #1;
        check("rd_flush_valid", bus.instr_valid, 0);
        check("rd_req_after",   bus.imem_req,    1);
        check("rd_addr_after",  bus.imem_addr,   32'h40);
        bus.instr_ready = 1'b1;
        tick();
        check("rd_n1_valid", bus.instr_valid, 0);
        tick();
        check("rd_n2_valid", bus.instr_valid, 1);
        check("rd_n2_pc",    bus.instr_pc,    32'h40);
        check("rd_n2_instr", bus.instr,       memf(32'h40));
        exp_pc = 32'h44;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rd_st_valid", bus.instr_valid, 1);
            check("rd_st_pc",    bus.instr_pc,    exp_pc);
            exp_pc = exp_pc + 4;
        end

        // PC wrap across 2^32.
        bus.redirect_en   = 1'b1;
        bus.redirect_addr = 32'hFFFF_FFF8;
        #1;
        check("wr_req", bus.imem_req, 0);
        tick();
        bus.redirect_en = 1'b0;
        #1;
        check("wr_a0", bus.imem_addr, 32'hFFFF_FFF8);
        tick();
        check("wr_a1", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wr_a2",   bus.imem_addr, 32'h0000_0000);
        check("wr_req2", bus.imem_req,  1);
        check("wr_pc0",  bus.instr_pc,  32'hFFFF_FFF8);
        tick();
        check("wr_pc1", bus.instr_pc, 32'hFFFF_FFFC);
        tick();
        check("wr_pc2",    bus.instr_pc, 32'h0000_0000);
        check("wr_instr2", bus.instr,    memf(32'h0));

`ifdef FETCH_MISALIGN_CHECK_EN
        bus.redirect_en   = 1'b1;
        bus.redirect_addr = 32'h42;
        tick();
        bus.redirect_en = 1'b0;
        #1;
        check("ma_err",  misalign_err,  1);
        check("ma_addr", bus.imem_addr, 32'h40);
        bus.redirect_en   = 1'b1;
        bus.redirect_addr = 32'h80;
        tick();
        bus.redirect_en = 1'b0;
        #1;
        check("ma_addr2",  bus.imem_addr, 32'h80);
        repeat (3) tick();
        check("ma_sticky", misalign_err,  1);
`endif

        // Asynchronous reset mid-stream discards queue and in-flight response.
        rst_n = 1'b0;
        #1;
        check("ar_req",   bus.imem_req,    0);
        check("ar_valid", bus.instr_valid, 0);
        check("ar_instr", bus.instr,       0);
        check("ar_pc",    bus.instr_pc,    0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("ar_misalign", misalign_err, 0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("ar_req_rel",  bus.imem_req,  1);
        check("ar_addr_rel", bus.imem_addr, 32'h0);
        tick();
        check("ar_n1_valid", bus.instr_valid, 0);
        tick();
        check("ar_n2_valid", bus.instr_valid, 1);
        check("ar_n2_pc",    bus.instr_pc,    32'h0);
        check("ar_n2_instr", bus.instr,       memf(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
